logic_gate_unit: RTL and testbench

LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

---
 rtl/logic_gate_pkg.sv | 20 ++
 rtl/gate_skid_buf.sv | 103 ++++++++++
 rtl/logic_gate_unit.sv | 81 ++++++++
 tb/tb_logic_gate_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
`default_nettype none
// ============================================================================
// logic_gate_pkg : operation encoding shared by the logic gate unit
// Revision: 1.0
// ============================================================================
package logic_gate_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_NAND = 3'd2;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
   localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
   localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage
`default_nettype wire

// File: rtl/gate_skid_buf.sv
`default_nettype none
// ============================================================================
// gate_skid_buf : 2-entry skid buffer, main entry drives outputs, ready is registered
// Revision: 1.0
// ============================================================================
module gate_skid_buf #(
   parameter int DATA_W = 9
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_MAIN  = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_ready;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic              w_accept;
   logic              w_drain;
   logic              w_load_main;
   logic              w_main_from_skid;
   logic              w_load_skid;

   assign w_accept = valid_i & r_ready;
   assign w_drain  = (r_state != ST_EMPTY) & ready_i;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_accept) begin
               w_load_main = 1'b1;
               w_state_nxt = ST_MAIN;
            end
         end
         ST_MAIN: begin
            if (w_accept && !w_drain) begin
               w_load_skid = 1'b1;
               w_state_nxt = ST_FULL;
            end else if (w_accept) begin
               w_load_main = 1'b1;
            end else if (w_drain) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // ready is low here, so no new data can arrive alongside the shift
            if (w_drain) begin
               w_main_from_skid = 1'b1;
               w_state_nxt      = ST_MAIN;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= ST_EMPTY;
         r_ready <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt != ST_FULL);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_main) begin
            r_main <= data_i;
         end else if (w_main_from_skid) begin
            r_main <= r_skid;
         end
         if (w_load_skid) begin
            r_skid <= data_i;
         end
      end
   end

   assign ready_o = r_ready;
   assign valid_o = (r_state != ST_EMPTY);
   assign data_o  = r_main;

endmodule
`default_nettype wire

// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// logic_gate_unit : bitwise gate ALU with valid/ready handshake and skid buffer
// Option macro GATE_STATS_EN adds cnt_o, a saturating output-handshake count.
// Revision: 1.0
// ============================================================================
module logic_gate_unit
   import logic_gate_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [OP_W-1:0]  op_i,
   input  logic [WIDTH-1:0] A_i,
   input  logic [WIDTH-1:0] B_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] F_o,
   output logic             Z_o
`ifdef GATE_STATS_EN
   ,
   output logic [15:0]      cnt_o
`endif
);

   logic [WIDTH-1:0] w_f;
   logic             w_z;
   logic [WIDTH:0]   w_payload_out;

   always_comb begin
      w_f = '0;
      case (op_i)
         OP_AND:  w_f = A_i & B_i;
         OP_OR:   w_f = A_i | B_i;
         OP_NAND: w_f = ~(A_i & B_i);
         OP_NOR:  w_f = ~(A_i | B_i);
         OP_XOR:  w_f = A_i ^ B_i;
         OP_XNOR: w_f = ~(A_i ^ B_i);
         OP_NOTA: w_f = ~A_i;
         OP_PASS: w_f = A_i;
         default: w_f = '0;
      endcase
   end

   assign w_z = ~|w_f;

   gate_skid_buf #(
      .DATA_W (WIDTH + 1)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  ({w_z, w_f}),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .data_o  (w_payload_out)
   );

   assign F_o = w_payload_out[WIDTH-1:0];
   assign Z_o = w_payload_out[WIDTH];

`ifdef GATE_STATS_EN
   logic [15:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
      end else if (valid_o && ready_i && (r_cnt != 16'hFFFF)) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign cnt_o = r_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
`default_nettype none
// Bench for logic_gate_unit (WIDTH=8): queue-based reference model plus directed vectors.
module tb_logic_gate_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid_i = 1'b0;
   logic       ready_i = 1'b0;
   logic [2:0] op = 3'd0;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       ready_o;
   logic       valid_o;
   logic [7:0] F_o;
   logic       Z_o;
`ifdef GATE_STATS_EN
   logic [15:0] cnt_o;
`endif

   logic_gate_unit #(.WIDTH(8)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .op_i    (op),
      .A_i     (a),
      .B_i     (b),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .F_o     (F_o),
      .Z_o     (Z_o)
`ifdef GATE_STATS_EN
      ,
      .cnt_o   (cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
   endtask

   // Truth table per op, indexed by {a_bit, b_bit}
   localparam logic [3:0] TT [0:7] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                                       4'b0110, 4'b1001, 4'b0011, 4'b1100};

   function automatic logic [7:0] ref_f(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      logic [7:0] r;
      logic [3:0] t;
      t = TT[o];
      for (int i = 0; i < 8; i++) r[i] = t[{x[i], y[i]}];
      return r;
   endfunction

   logic [8:0] q[$];
   int cyc = 0;
   int hs_cnt = 0;
   int hs_since_rst = 0;
   int last_hs = -10;
   int streak = 0;

   always @(negedge rst_n) begin
      q.delete();
      hs_since_rst = 0;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         cyc++;
         if (valid_o && ready_i && q.size() != 0) begin
            void'(q.pop_front());
            hs_cnt++;
            hs_since_rst++;
            streak = (last_hs == cyc - 1) ? streak + 1 : 1;
            last_hs = cyc;
         end
         if (valid_i && ready_o) begin
            logic [7:0] f;
            f = ref_f(op, a, b);
            q.push_back({(f == 8'h00), f});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("valid_o", valid_o, q.size() != 0);
         chk("ready_o", ready_o, q.size() < 2);
         if (q.size() != 0) begin
            chk("F_o", F_o, q[0][7:0]);
            chk("Z_o", Z_o, q[0][8]);
         end
`ifdef GATE_STATS_EN
         chk("cnt_o", cnt_o, (hs_since_rst > 65535) ? 65535 : hs_since_rst);
`endif
      end
   end

   task automatic lit(input string nm, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] ef, input logic ez);
      chk({nm, "_model"}, ref_f(o, x, y), ef);
      valid_i = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(negedge clk);
      chk({nm, "_valid"}, valid_o, 1'b1);
      chk({nm, "_F"}, F_o, ef);
      chk({nm, "_Z"}, Z_o, ez);
      @(posedge clk); #1;
   endtask

   task automatic stream(input int n);
      valid_i = 1'b1;
      for (int i = 0; i < n; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = 8'($urandom);
         b  = 8'($urandom);
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      int hs0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_F", F_o, 8'h00);
      chk("rst_Z", Z_o, 1'b0);
      @(negedge clk); #1;
      rst_n = 1'b1;
      ready_i = 1'b1;
      @(posedge clk); #1;

      lit("nor", 3'd3, 8'h0F, 8'h30, 8'hC0, 1'b0);
      lit("xor", 3'd4, 8'hFF, 8'hFF, 8'h00, 1'b1);
      lit("nota", 3'd6, 8'hA5, 8'h77, 8'h5A, 1'b0);
      lit("nand", 3'd2, 8'hF0, 8'h3C, 8'hCF, 1'b0);

      // Back-pressure: two accepted, third offered while full
      ready_i = 1'b0;
      valid_i = 1'b1; op = 3'd0; a = 8'h12; b = 8'h34;
      @(posedge clk); #1;
      op = 3'd1;
      @(posedge clk); #1;
      chk("stall_ready_lo", ready_o, 1'b0);
      op = 3'd2;
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("stall_hold_F", F_o, 8'h10);
      chk("stall_depth", q.size(), 2);
      ready_i = 1'b1;
      @(posedge clk); #1;
      chk("drain_second_F", F_o, 8'h36);
      chk("ready_back", ready_o, 1'b1);
      @(posedge clk); #1;
      chk("drain_empty", valid_o, 1'b0);

      // Full-rate streaming
      hs0 = hs_cnt;
      stream(100);
      chk("stream_count", hs_cnt - hs0, 100);
      chk("stream_streak", streak, 100);

      // Mixed back-pressure with random data
      valid_i = 1'b1;
      for (int i = 0; i < 60; i++) begin
         ready_i = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
         a = 8'($urandom);
         b = 8'($urandom);
         @(posedge clk); #1;
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("mixed_drained", q.size(), 0);

      // Asynchronous reset with both entries full
      ready_i = 1'b0;
      valid_i = 1'b1; op = 3'd7; a = 8'h81; b = 8'h00;
      @(posedge clk); #1;
      a = 8'h42;
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("full_ready_lo", ready_o, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", valid_o, 1'b0);
      chk("arst_ready", ready_o, 1'b1);
      chk("arst_F", F_o, 8'h00);
      chk("arst_Z", Z_o, 1'b0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      ready_i = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", valid_o, 1'b0);
      @(posedge clk); #1;
      lit("pass", 3'd7, 8'h3C, 8'hFF, 8'h3C, 1'b0);
      lit("xnor", 3'd5, 8'h0F, 8'hF0, 8'h00, 1'b1);

`ifdef GATE_STATS_EN
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      stream(65537);
      chk("cnt_saturate", cnt_o, 16'hFFFF);
`endif

      chk("final_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
